// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared types and helpers for the register-bus arbiter.
//   arb_state_e  - arbiter FSM state encoding
//   lat_cnt_w()  - width of the read-latency down-counter for a given RD_LAT
package reg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  // The counter is loaded with RD_LAT-1 and counts down to zero.
  function automatic int lat_cnt_w(input int rd_lat);
    return (rd_lat > 2) ? $clog2(rd_lat) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  N_MST  request vector
//   last  in  IDX_W  index of the previous winner; search starts at last+1
//   grant out N_MST  one-hot winner (all zero when no request)
//   idx   out IDX_W  winner index (0 when no request)
module rr_pick #(
  parameter int N_MST = 2,
  parameter int IDX_W = $clog2(N_MST)
) (
  input  logic [N_MST-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_MST-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk last+1 .. last+N_MST (mod N_MST); the previous winner is visited last.
    for (int i = 1; i <= N_MST; i++) begin
      cand = IDX_W'((int'(last) + i) % N_MST);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: shares one register bus between N_MST masters, one transaction
// at a time. Grants in IDLE, strobes reg_req for one cycle, waits RD_LAT cycles
// for read data, then pulses m_ack to the winner.
//
// Build option: define REG_ARB_PRIO_EN to give master 0 fixed top priority;
// the other masters then rotate among themselves.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m_req/m_wr            per-master request level and write(1)/read(0)
//   m_addr/m_wdata        per-master address/data, master i at slice i
//   m_ack                 one-hot completion pulse
//   m_rdata               last captured read data
//   reg_req/reg_wr        bus strobe (one cycle per transaction) and write enable
//   reg_addr/reg_wdata    bus address/data, held until the next grant
//   reg_rdata             bus read data, valid RD_LAT cycles after reg_req
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; grant the picked requester if any
// ST_ISSUE | reg_req high for one cycle with the latched command
// ST_WAIT  | counting down the slave read latency, capture at zero
// ST_ACK   | one-cycle m_ack to the granted master
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int REG_AW = 8,
  parameter int REG_DW = 32,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MST-1:0]        m_req,
  input  logic [N_MST-1:0]        m_wr,
  input  logic [N_MST*REG_AW-1:0] m_addr,
  input  logic [N_MST*REG_DW-1:0] m_wdata,
  output logic [N_MST-1:0]        m_ack,
  output logic [REG_DW-1:0]       m_rdata,
  output logic                    reg_req,
  output logic                    reg_wr,
  output logic [REG_AW-1:0]       reg_addr,
  output logic [REG_DW-1:0]       reg_wdata,
  input  logic [REG_DW-1:0]       reg_rdata
);

  localparam int IDX_W = $clog2(N_MST);
  localparam int CNT_W = lat_cnt_w(RD_LAT);

  arb_state_e       state_q, state_d;
  logic [N_MST-1:0] gnt_oh_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [CNT_W-1:0] lat_cnt_q;

  logic [N_MST-1:0]  pick_req;
  logic [N_MST-1:0]  rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic [N_MST-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              upd_last;
  logic              grant_fire;
  logic              sel_wr;
  logic [REG_AW-1:0] sel_addr;
  logic [REG_DW-1:0] sel_wdata;

`ifdef REG_ARB_PRIO_EN
  // Master 0 is handled outside the rotation and never moves last_grant.
  assign pick_req = {m_req[N_MST-1:1], 1'b0};

  always_comb begin
    win_oh   = rr_grant;
    win_idx  = rr_idx;
    upd_last = 1'b1;
    if (m_req[0]) begin
      win_oh   = N_MST'(1);
      win_idx  = '0;
      upd_last = 1'b0;
    end
  end
`else
  assign pick_req = m_req;
  assign win_oh   = rr_grant;
  assign win_idx  = rr_idx;
  assign upd_last = 1'b1;
`endif

  rr_pick #(
    .N_MST (N_MST),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (pick_req),
    .last  (last_grant_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  assign grant_fire = (state_q == ST_IDLE) && (|m_req);

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (win_oh[i]) begin
        sel_wr    = m_wr[i];
        sel_addr  = m_addr[i*REG_AW +: REG_AW];
        sel_wdata = m_wdata[i*REG_DW +: REG_DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|m_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = reg_wr ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (lat_cnt_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    reg_req = (state_q == ST_ISSUE);
    m_ack   = (state_q == ST_ACK) ? gnt_oh_q : '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_oh_q     <= '0;
      last_grant_q <= IDX_W'(N_MST - 1);
      lat_cnt_q    <= '0;
      reg_wr       <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      m_rdata      <= '0;
    end else begin
      if (grant_fire) begin
        gnt_oh_q  <= win_oh;
        reg_wr    <= sel_wr;
        reg_addr  <= sel_addr;
        reg_wdata <= sel_wdata;
        if (upd_last) last_grant_q <= win_idx;
      end
      if (state_q == ST_ISSUE) lat_cnt_q <= CNT_W'(RD_LAT - 1);
      if (state_q == ST_WAIT) begin
        if (lat_cnt_q == '0) m_rdata   <= reg_rdata;
        else                 lat_cnt_q <= lat_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_arb.sv
`timescale 1ns/1ps
module tb_reg_bus_arb;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int A_N   = 2;
  localparam int A_LAT = 1;
  localparam int B_N   = 3;
  localparam int B_LAT = 3;
  localparam logic [DW-1:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: two masters, read latency 1
  logic [A_N-1:0]    a_m_req, a_m_wr, a_m_ack;
  logic [A_N*AW-1:0] a_m_addr;
  logic [A_N*DW-1:0] a_m_wdata;
  logic [DW-1:0]     a_m_rdata, a_reg_wdata, a_reg_rdata;
  logic              a_reg_req, a_reg_wr;
  logic [AW-1:0]     a_reg_addr;

  // Instance B: three masters, read latency 3
  logic [B_N-1:0]    b_m_req, b_m_wr, b_m_ack;
  logic [B_N*AW-1:0] b_m_addr;
  logic [B_N*DW-1:0] b_m_wdata;
  logic [DW-1:0]     b_m_rdata, b_reg_wdata, b_reg_rdata;
  logic              b_reg_req, b_reg_wr;
  logic [AW-1:0]     b_reg_addr;

  reg_bus_arb #(.N_MST(A_N), .REG_AW(AW), .REG_DW(DW), .RD_LAT(A_LAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .m_req(a_m_req), .m_wr(a_m_wr), .m_addr(a_m_addr),
    .m_wdata(a_m_wdata), .m_ack(a_m_ack), .m_rdata(a_m_rdata), .reg_req(a_reg_req),
    .reg_wr(a_reg_wr), .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata), .reg_rdata(a_reg_rdata)
  );

  reg_bus_arb #(.N_MST(B_N), .REG_AW(AW), .REG_DW(DW), .RD_LAT(B_LAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_req(b_m_req), .m_wr(b_m_wr), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_ack(b_m_ack), .m_rdata(b_m_rdata), .reg_req(b_reg_req),
    .reg_wr(b_reg_wr), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_rdata(b_reg_rdata)
  );

  // Slave models: memory plus a read pipeline; data is only valid RD_LAT cycles after reg_req.
  logic [DW-1:0] a_mem [256];
  logic [A_LAT-1:0] a_pv = '0;
  logic [DW-1:0] a_pd [A_LAT];
  always @(posedge clk) begin
    if (a_reg_req && a_reg_wr) a_mem[a_reg_addr] <= a_reg_wdata;
    a_pv[0] <= a_reg_req && !a_reg_wr;
    a_pd[0] <= a_mem[a_reg_addr];
    for (int k = 1; k < A_LAT; k++) begin
      a_pv[k] <= a_pv[k-1];
      a_pd[k] <= a_pd[k-1];
    end
  end
  assign a_reg_rdata = a_pv[A_LAT-1] ? a_pd[A_LAT-1] : BAD;

  logic [DW-1:0] b_mem [256];
  logic [B_LAT-1:0] b_pv = '0;
  logic [DW-1:0] b_pd [B_LAT];
  always @(posedge clk) begin
    if (b_reg_req && b_reg_wr) b_mem[b_reg_addr] <= b_reg_wdata;
    b_pv[0] <= b_reg_req && !b_reg_wr;
    b_pd[0] <= b_mem[b_reg_addr];
    for (int k = 1; k < B_LAT; k++) begin
      b_pv[k] <= b_pv[k-1];
      b_pd[k] <= b_pd[k-1];
    end
  end
  assign b_reg_rdata = b_pv[B_LAT-1] ? b_pd[B_LAT-1] : BAD;

  // Drivers: called at a negedge with the DUT idle; the request is seen in this cycle (t).
  // lat is the number of cycles from t to the ack cycle (-1 if none within the budget).
  task automatic run_a(input int m, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int lat, output int nreq,
                       output logic [A_N-1:0] ackv, output logic [DW-1:0] rd,
                       output logic [A_N-1:0] ack_next, output logic iss_wr,
                       output logic [AW-1:0] iss_addr, output logic [DW-1:0] iss_wd);
    a_m_req[m] = 1'b1; a_m_wr[m] = wr;
    a_m_addr[m*AW +: AW] = addr; a_m_wdata[m*DW +: DW] = wd;
    lat = -1; nreq = 0; ackv = '0; rd = '0; iss_wr = 1'b0; iss_addr = '0; iss_wd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_reg_req) begin
        nreq++; iss_wr = a_reg_wr; iss_addr = a_reg_addr; iss_wd = a_reg_wdata;
      end
      if (a_m_ack != '0) begin
        lat = c; ackv = a_m_ack; rd = a_m_rdata;
        break;
      end
    end
    a_m_req[m] = 1'b0;
    @(negedge clk);
    ack_next = a_m_ack;
  endtask

  task automatic run_b(input int m, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int lat, output int nreq,
                       output logic [B_N-1:0] ackv, output logic [DW-1:0] rd);
    b_m_req[m] = 1'b1; b_m_wr[m] = wr;
    b_m_addr[m*AW +: AW] = addr; b_m_wdata[m*DW +: DW] = wd;
    lat = -1; nreq = 0; ackv = '0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_reg_req) nreq++;
      if (b_m_ack != '0) begin
        lat = c; ackv = b_m_ack; rd = b_m_rdata;
        break;
      end
    end
    b_m_req[m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_m_req = '0; a_m_wr = '0; a_m_addr = '0; a_m_wdata = '0;
    b_m_req = '0; b_m_wr = '0; b_m_addr = '0; b_m_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_reg_req !== 1'b0) begin n_fail++; $display("FAIL rst_a_reg_req: got %b want 0", a_reg_req); end
    n_checks++; if (a_reg_wr !== 1'b0) begin n_fail++; $display("FAIL rst_a_reg_wr: got %b want 0", a_reg_wr); end
    n_checks++; if (a_reg_addr !== '0) begin n_fail++; $display("FAIL rst_a_reg_addr: got %h want 0", a_reg_addr); end
    n_checks++; if (a_reg_wdata !== '0) begin n_fail++; $display("FAIL rst_a_reg_wdata: got %h want 0", a_reg_wdata); end
    n_checks++; if (a_m_ack !== '0) begin n_fail++; $display("FAIL rst_a_m_ack: got %b want 0", a_m_ack); end
    n_checks++; if (a_m_rdata !== '0) begin n_fail++; $display("FAIL rst_a_m_rdata: got %h want 0", a_m_rdata); end
    n_checks++; if (b_reg_req !== 1'b0 || b_m_ack !== '0) begin n_fail++; $display("FAIL rst_b_req_ack: got %b/%b want 0/0", b_reg_req, b_m_ack); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int lat, nreq; logic [A_N-1:0] ackv, ackn; logic [DW-1:0] rd, iwd; logic iwr; logic [AW-1:0] iad;
    run_a(1, 1'b1, 8'h10, 32'hDEADBEEF, lat, nreq, ackv, rd, ackn, iwr, iad, iwd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_lat: got %0d want 2", lat); end
    n_checks++; if (nreq !== 1) begin n_fail++; $display("FAIL write_nreq: got %0d want 1", nreq); end
    n_checks++; if (ackv !== 2'b10) begin n_fail++; $display("FAIL write_ack: got %b want 10", ackv); end
    n_checks++; if (ackn !== 2'b00) begin n_fail++; $display("FAIL write_ack_len: got %b want 00", ackn); end
    n_checks++; if (iwr !== 1'b1 || iad !== 8'h10 || iwd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_bus: got wr=%b addr=%h wd=%h want 1/10/deadbeef", iwr, iad, iwd); end
  endtask

  task automatic test_read_lat1();
    int lat, nreq; logic [A_N-1:0] ackv, ackn; logic [DW-1:0] rd, iwd; logic iwr; logic [AW-1:0] iad;
    run_a(0, 1'b0, 8'h10, 32'h0, lat, nreq, ackv, rd, ackn, iwr, iad, iwd);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read1_lat: got %0d want 3", lat); end
    n_checks++; if (ackv !== 2'b01) begin n_fail++; $display("FAIL read1_ack: got %b want 01", ackv); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read1_data: got %h want deadbeef", rd); end
    n_checks++; if (nreq !== 1 || iwr !== 1'b0 || iad !== 8'h10) begin
      n_fail++; $display("FAIL read1_bus: got n=%0d wr=%b addr=%h want 1/0/10", nreq, iwr, iad); end
    n_checks++; if (ackn !== 2'b00) begin n_fail++; $display("FAIL read1_ack_len: got %b want 00", ackn); end
  endtask

  task automatic test_rdata_hold();
    int lat, nreq; logic [A_N-1:0] ackv, ackn; logic [DW-1:0] rd, iwd; logic iwr; logic [AW-1:0] iad;
    run_a(1, 1'b1, 8'h20, 32'h12345678, lat, nreq, ackv, rd, ackn, iwr, iad, iwd);
    repeat (2) @(negedge clk);
    n_checks++; if (a_m_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_rdata: got %h want deadbeef", a_m_rdata); end
    n_checks++; if (a_reg_wr !== 1'b1 || a_reg_addr !== 8'h20 || a_reg_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL hold_bus: got wr=%b addr=%h wd=%h want 1/20/12345678", a_reg_wr, a_reg_addr, a_reg_wdata); end
    run_a(0, 1'b0, 8'h20, 32'h0, lat, nreq, ackv, rd, ackn, iwr, iad, iwd);
    n_checks++; if (rd !== 32'h12345678 || lat !== 3) begin
      n_fail++; $display("FAIL hold_read2: got %h lat %0d want 12345678 lat 3", rd, lat); end
  endtask

  task automatic test_read_lat3();
    int lat, nreq; logic [B_N-1:0] ackv; logic [DW-1:0] rd;
    run_b(0, 1'b1, 8'h10, 32'hDEADBEEF, lat, nreq, ackv, rd);
    n_checks++; if (lat !== 2 || ackv !== 3'b001) begin n_fail++; $display("FAIL read3_wr: got lat %0d ack %b want 2/001", lat, ackv); end
    run_b(0, 1'b0, 8'h10, 32'h0, lat, nreq, ackv, rd);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL read3_lat: got %0d want 5", lat); end
    n_checks++; if (ackv !== 3'b001) begin n_fail++; $display("FAIL read3_ack: got %b want 001", ackv); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read3_data: got %h want deadbeef", rd); end
    n_checks++; if (nreq !== 1) begin n_fail++; $display("FAIL read3_nreq: got %0d want 1", nreq); end
  endtask

  task automatic test_contention();
    int got, last_c, nreq;
    logic [A_N-1:0] exp;
    do_reset();
    a_m_req = 2'b11; a_m_wr = 2'b11;
    a_m_addr = {8'h31, 8'h30}; a_m_wdata = {32'h1111_1111, 32'h0000_0000};
    got = 0; last_c = 0; nreq = 0;
    for (int c = 1; c <= 40 && got < 6; c++) begin
      @(negedge clk);
      if (a_reg_req) nreq++;
      if (a_m_ack != '0) begin
        exp = (got % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++; if (a_m_ack !== exp) begin n_fail++; $display("FAIL contend_ack%0d: got %b want %b", got, a_m_ack, exp); end
        if (got > 0) begin
          n_checks++; if (c - last_c !== 3) begin n_fail++; $display("FAIL contend_period%0d: got %0d want 3", got, c - last_c); end
        end
        last_c = c;
        got++;
      end
    end
    a_m_req = '0;
    @(negedge clk);
    n_checks++; if (got !== 6 || nreq !== 6) begin n_fail++; $display("FAIL contend_count: got acks %0d reqs %0d want 6/6", got, nreq); end
  endtask

  task automatic test_priority();
    int got, last_c;
    logic [B_N-1:0] exp_seq [7];
`ifdef REG_ARB_PRIO_EN
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
`else
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
`endif
    do_reset();
    b_m_req = 3'b111; b_m_wr = 3'b111;
    b_m_addr = {8'h42, 8'h41, 8'h40}; b_m_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0};
    got = 0; last_c = 0;
    for (int c = 1; c <= 60 && got < 7; c++) begin
      @(negedge clk);
      if (b_m_ack != '0) begin
        n_checks++; if (b_m_ack !== exp_seq[got]) begin n_fail++; $display("FAIL prio_ack%0d: got %b want %b", got, b_m_ack, exp_seq[got]); end
        if (got > 0) begin
          n_checks++; if (c - last_c !== 3) begin n_fail++; $display("FAIL prio_period%0d: got %0d want 3", got, c - last_c); end
        end
        last_c = c;
        got++;
        if (got == 3) b_m_req[0] = 1'b0;
      end
    end
    b_m_req = '0;
    @(negedge clk);
    n_checks++; if (got !== 7) begin n_fail++; $display("FAIL prio_count: got %0d want 7", got); end
  endtask

  task automatic test_reset_mid();
    int n_ack, n_req;
    logic [B_N-1:0] first;
    b_m_req[1] = 1'b1; b_m_wr[1] = 1'b0; b_m_addr[1*AW +: AW] = 8'h10;
    repeat (2) @(negedge clk);  // now in the first WAIT cycle
    rst_n = 1'b0; b_m_req = '0;
    @(negedge clk);
    n_checks++; if (b_reg_req !== 1'b0 || b_m_ack !== '0) begin n_fail++; $display("FAIL midrst_req_ack: got %b/%b want 0/0", b_reg_req, b_m_ack); end
    n_checks++; if (b_reg_wr !== 1'b0 || b_reg_addr !== '0 || b_reg_wdata !== '0) begin
      n_fail++; $display("FAIL midrst_bus: got wr=%b addr=%h wd=%h want 0", b_reg_wr, b_reg_addr, b_reg_wdata); end
    n_checks++; if (b_m_rdata !== '0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", b_m_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0; n_req = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_m_ack != '0) n_ack++;
      if (b_reg_req) n_req++;
    end
    n_checks++; if (n_ack !== 0 || n_req !== 0) begin n_fail++; $display("FAIL midrst_quiet: got acks %0d reqs %0d want 0/0", n_ack, n_req); end
    b_m_req = 3'b111; b_m_wr = 3'b111;
    first = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_m_ack != '0) begin first = b_m_ack; break; end
    end
    b_m_req = '0;
    @(negedge clk);
    n_checks++; if (first !== 3'b001) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 001", first); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_lat1();
    test_rdata_hold();
    test_read_lat3();
    test_contention();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_arb.md
# reg_bus_arb

Shares one register bus (reg_req/reg_wr/reg_addr/reg_wdata/reg_rdata, as driven by reg_bus_if) between N_MST requesters. Sits between bus masters (sequencers, CPU stubs, DMA-style config engines) and a memory-mapped register slave such as mmreg_dummy. It arbitrates one transaction at a time, drives the bus, captures read data after a fixed slave latency and returns a one-cycle acknowledge to the winner.

## Interface
- N_MST, 2, number of requesters (≥2)
- REG_AW, 8, register address width
- REG_DW, 32, register data width
- RD_LAT, 1, slave read latency in cycles (≥1): reg_rdata valid RD_LAT cycles after the reg_req cycle

- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- m_req  in  N_MST  per-master request level
- m_wr  in  N_MST  per-master write (1) / read (0)
- m_addr  in  N_MST*REG_AW  master i address at slice [i*REG_AW +: REG_AW]
- m_wdata  in  N_MST*REG_DW  master i write data at slice [i*REG_DW +: REG_DW]
- m_ack  out  N_MST  one-hot completion pulse
- m_rdata  out  REG_DW  read data, valid with m_ack of a read
- reg_req  out  1  bus request strobe, one cycle per transaction
- reg_wr  out  1  bus write enable
- reg_addr  out  REG_AW  bus address
- reg_wdata  out  REG_DW  bus write data
- reg_rdata  in  REG_DW  bus read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any m_req, pick winner g, register g, m_wr[g], m_addr slice, m_wdata slice → ISSUE; else stay.
- ISSUE: reg_req=1 for exactly one cycle with registered wr/addr/wdata. Write → ACK. Read → WAIT.
- WAIT: counter runs RD_LAT cycles; on the cycle reg_rdata is valid, capture into m_rdata register → ACK.
- ACK: m_ack[g]=1 for one cycle → IDLE.
- Master contract: hold m_req, m_wr, m_addr, m_wdata stable from request through its ack cycle. m_req still high in the cycle after ack is a new request.
- Arbitration default: round-robin. Search starts at last_grant+1 mod N_MST. last_grant updates on every grant.
- Requests arriving while busy are ignored until next IDLE; no queueing.
- m_rdata holds its last captured value until the next read capture. It is not updated by writes.

## Timing
- Reset values: state IDLE, reg_req 0, reg_wr 0, reg_addr 0, reg_wdata 0, m_ack 0, m_rdata 0, last_grant N_MST-1 (master 0 wins first).
- Grant in IDLE cycle t. reg_req at t+1.
- Write: m_ack at t+2. Back-to-back issue period is 3 cycles.
- Read: reg_rdata sampled at end of cycle t+1+RD_LAT. m_ack and m_rdata valid at t+2+RD_LAT.
- reg_wr/addr/wdata stay stable from ISSUE until the next grant.
- Reset asserted mid-transaction: next edge forces IDLE with all outputs at reset values. No ack is produced for the aborted transaction, and the slave sees no further reg_req.
- Simultaneous requests: exactly one grant per IDLE cycle.

## Configuration
- REG_ARB_PRIO_EN defined: master 0 is fixed highest priority. It wins any IDLE cycle in which m_req[0]=1. The remaining masters rotate round-robin among themselves, and last_grant updates only for masters ≥1.
- Undefined: pure round-robin over all masters, as above.

## Structure
- Package reg_bus_pkg holds the FSM state enum (arb_state_e) and the RD_LAT counter width helper constant.
- One sub-module, rr_pick: combinational round-robin picker with inputs req vector and last index, outputs one-hot grant and index. Parameterised by N_MST.
- Top-level reg_bus_arb holds the FSM, registers and the priority override.

## Test plan
- Single write: master 1 writes 0xDEADBEEF to 0x10 → one reg_req cycle with reg_wr=1, reg_addr=0x10; m_ack[1] exactly 2 cycles after the grant cycle; readback of 0x10 returns 0xDEADBEEF.
- Single read, RD_LAT=1 and RD_LAT=3: master 0 reads 0x10 → m_ack[0] at t+3 and t+5 respectively, with m_rdata=0xDEADBEEF.
- Contention: masters 0 and 1 hold continuous requests for 6 transactions → grants alternate 0,1,0,1,0,1 and no ack overlaps.
- REG_ARB_PRIO_EN with N_MST=3, all requesting continuously → grants 0,0,0,… while m_req[0]=1. After m_req[0] drops, grants alternate 1,2.
- Reset during WAIT of a read → no m_ack, all outputs 0 the cycle after reset. The first post-reset grant goes to master 0.
